// File: rtl/pulse_xfer_sched.sv
// Round-robin scheduler sharing one toggle-based CDC channel among N pulse requesters.
// Each grant drives its ID, then flips xfer_tgl and waits for the far side's toggle ack.
module pulse_xfer_sched #(
  parameter int unsigned N           = 4,
  parameter int unsigned IDW         = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TMO_CYC     = 1023
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_pulse,
  input  logic [N-1:0]   ovf_clr,
  input  logic           err_clr,
  input  logic           ack_tgl,
  output logic           xfer_tgl,
  output logic [IDW-1:0] xfer_id,
  output logic           busy,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow,
  output logic           tmo_err
);

  localparam int unsigned CW = $clog2(TMO_CYC + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IDW-1:0]         rr_q, rr_d;
  logic [IDW-1:0]         id_q, id_d;
  logic                   tgl_q, tgl_d;
  logic [N-1:0]           pend_q, pend_d;
  logic [N-1:0]           ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   tmo_set;

  logic                   hi_vld, lo_vld, gnt_vld;
  int unsigned            hi_idx, lo_idx, gnt_idx, gnt_nxt;
  logic [N-1:0]           gnt_mask;

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Round-robin: first pending bit at or above rr_q, otherwise first pending bit overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = 0;
    lo_vld = 1'b0;
    lo_idx = 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!hi_vld && pend_q[j] && (j >= 32'(rr_q))) begin
        hi_vld = 1'b1;
        hi_idx = j;
      end
      if (!lo_vld && pend_q[j]) begin
        lo_vld = 1'b1;
        lo_idx = j;
      end
    end
    gnt_vld = hi_vld | lo_vld;
    gnt_idx = hi_vld ? hi_idx : lo_idx;
    gnt_nxt = (gnt_idx + 1 >= N) ? 0 : gnt_idx + 1;
  end

  always_comb begin
    gnt_mask = '0;
    for (int unsigned j = 0; j < N; j++) begin
      gnt_mask[j] = (state_q == ST_IDLE) && gnt_vld && (j == gnt_idx);
    end
  end

  // A pulse landing on its own grant edge re-queues rather than overflowing.
  always_comb begin
    pend_d = (pend_q & ~gnt_mask) | req_pulse;
    ovf_d  = (ovf_q & ~ovf_clr) | (req_pulse & pend_q & ~gnt_mask);
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    tgl_d   = tgl_q;
    cnt_d   = cnt_q;
    tmo_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          id_d    = IDW'(gnt_idx);
          rr_d    = IDW'(gnt_nxt);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tgl_d   = ~tgl_q;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_s == tgl_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q != CW'(TMO_CYC)) begin
          cnt_d = cnt_q + 1'b1;
          // Flag only on the step into saturation so err_clr works while still waiting.
          tmo_set = (cnt_q == CW'(TMO_CYC - 1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = (err_q & ~err_clr) | tmo_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      tgl_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      tgl_q   <= tgl_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_tgl};
    end
  end

  assign xfer_tgl = tgl_q;
  assign xfer_id  = id_q;
  assign busy     = (state_q != ST_IDLE);
  assign pending  = pend_q;
  assign overflow = ovf_q;
  assign tmo_err  = err_q;

endmodule

// File: tb/tb_pulse_xfer_sched.sv
// Directed bench for pulse_xfer_sched with a far-side model echoing xfer_tgl after 4 clk.
module tb_pulse_xfer_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_pulse = '0;
  logic [N-1:0]   ovf_clr = '0;
  logic           err_clr = 1'b0;
  logic           ack_tgl;
  logic           xfer_tgl;
  logic [IDW-1:0] xfer_id;
  logic           busy;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;
  logic           tmo_err;

  int errors = 0;
  int checks = 0;

  pulse_xfer_sched #(
    .N(N), .IDW(IDW), .SYNC_STAGES(2), .TMO_CYC(15)
  ) dut (
    .clk(clk), .reset(reset), .req_pulse(req_pulse), .ovf_clr(ovf_clr),
    .err_clr(err_clr), .ack_tgl(ack_tgl), .xfer_tgl(xfer_tgl), .xfer_id(xfer_id),
    .busy(busy), .pending(pending), .overflow(overflow), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  // Far-side model: echoes the toggle after a 4-cycle delay line when enabled.
  logic       far_en = 1'b1;
  logic [3:0] dly;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dly     <= '0;
      ack_tgl <= 1'b0;
    end else begin
      dly <= {dly[2:0], xfer_tgl};
      if (far_en) ack_tgl <= dly[3];
    end
  end

  // Transfer log: records xfer_id at every toggle flip; notes a flip issued before the previous ack.
  int   idlog [0:63];
  int   log_n = 0;
  logic last_tgl = 1'b0;
  logic flip_bad = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      last_tgl = 1'b0;
    end else if (xfer_tgl != last_tgl) begin
      if (ack_tgl != last_tgl) flip_bad = 1'b1;
      if (log_n < 64) idlog[log_n] = int'(xfer_id);
      log_n    = log_n + 1;
      last_tgl = xfer_tgl;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_quiet(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!busy && pending == '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    req_pulse = v;
    tick();
    req_pulse = '0;
  endtask

  int base;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_tgl", {31'd0, xfer_tgl}, 32'd0);
    chk("rst_id", {30'd0, xfer_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pend", {28'd0, pending}, 32'd0);
    chk("rst_ovf", {28'd0, overflow}, 32'd0);
    chk("rst_err", {31'd0, tmo_err}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: single event on ch2
    base = log_n;
    pulse(4'b0100);
    chk("t1_pend", {28'd0, pending}, 32'h4);
    chk("t1_busy0", {31'd0, busy}, 32'd0);
    tick();
    chk("t1_id", {30'd0, xfer_id}, 32'd2);
    chk("t1_tgl_pre", {31'd0, xfer_tgl}, 32'd0);
    chk("t1_busy1", {31'd0, busy}, 32'd1);
    chk("t1_pend_clr", {28'd0, pending}, 32'd0);
    tick();
    chk("t1_tgl_flip", {31'd0, xfer_tgl}, 32'd1);
    chk("t1_id_hold", {30'd0, xfer_id}, 32'd2);
    wait_quiet("t1_quiet");
    chk("t1_log_n", 32'(log_n - base), 32'd1);
    chk("t1_log0", 32'(idlog[base]), 32'd2);

    // 2: all four at once, served 0..3
    do_reset();
    base = log_n;
    pulse(4'b1111);
    chk("t2_pend", {28'd0, pending}, 32'hF);
    wait_quiet("t2_quiet");
    chk("t2_log_n", 32'(log_n - base), 32'd4);
    chk("t2_id0", 32'(idlog[base]), 32'd0);
    chk("t2_id1", 32'(idlog[base+1]), 32'd1);
    chk("t2_id2", 32'(idlog[base+2]), 32'd2);
    chk("t2_id3", 32'(idlog[base+3]), 32'd3);
    chk("t2_ovf", {28'd0, overflow}, 32'd0);
    chk("t2_tgl", {31'd0, xfer_tgl}, 32'd0);

    // 3: ch0 re-pulses while ch3 waits; ch3 must go before ch0's second event
    do_reset();
    base = log_n;
    pulse(4'b1001);
    tick();
    tick();
    pulse(4'b0001);
    chk("t3_pend", {28'd0, pending}, 32'h9);
    wait_quiet("t3_quiet");
    chk("t3_log_n", 32'(log_n - base), 32'd3);
    chk("t3_id0", 32'(idlog[base]), 32'd0);
    chk("t3_id1", 32'(idlog[base+1]), 32'd3);
    chk("t3_id2", 32'(idlog[base+2]), 32'd0);
    chk("t3_ovf", {28'd0, overflow}, 32'd0);

    // 4: overflow, clear, and pulse on the grant edge
    do_reset();
    base = log_n;
    pulse(4'b0001);
    tick();
    pulse(4'b0010);
    chk("t4_ovf_none", {28'd0, overflow}, 32'd0);
    pulse(4'b0010);
    chk("t4_ovf_set", {28'd0, overflow}, 32'h2);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = '0;
    chk("t4_ovf_clr", {28'd0, overflow}, 32'd0);
    wait_idle("t4_idle");
    chk("t4_pend_pre", {28'd0, pending}, 32'h2);
    pulse(4'b0010);
    chk("t4_gnt_id", {30'd0, xfer_id}, 32'd1);
    chk("t4_gnt_pend", {28'd0, pending}, 32'h2);
    chk("t4_gnt_ovf", {28'd0, overflow}, 32'd0);
    wait_quiet("t4_quiet");
    chk("t4_log_n", 32'(log_n - base), 32'd3);
    chk("t4_id0", 32'(idlog[base]), 32'd0);
    chk("t4_id1", 32'(idlog[base+1]), 32'd1);
    chk("t4_id2", 32'(idlog[base+2]), 32'd1);

    // 5: timeout with TMO_CYC=15, late ack, then err_clr
    do_reset();
    far_en = 1'b0;
    pulse(4'b0100);
    tick();
    tick();
    chk("t5_tgl", {31'd0, xfer_tgl}, 32'd1);
    repeat (14) tick();
    chk("t5_err_pre", {31'd0, tmo_err}, 32'd0);
    tick();
    chk("t5_err_set", {31'd0, tmo_err}, 32'd1);
    repeat (5) tick();
    chk("t5_still_busy", {31'd0, busy}, 32'd1);
    far_en = 1'b1;
    wait_idle("t5_late_ack");
    chk("t5_err_sticky", {31'd0, tmo_err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_err_clr", {31'd0, tmo_err}, 32'd0);

    // 6: reset in WAIT, reset in SEND, then a clean ch0 transfer
    do_reset();
    pulse(4'b0010);
    tick();
    tick();
    pulse(4'b1000);
    chk("t6_busy_wait", {31'd0, busy}, 32'd1);
    chk("t6_tgl_wait", {31'd0, xfer_tgl}, 32'd1);
    chk("t6_pend_wait", {28'd0, pending}, 32'h8);
    #2;
    reset = 1'b1;
    #1;
    chk("t6w_tgl", {31'd0, xfer_tgl}, 32'd0);
    chk("t6w_id", {30'd0, xfer_id}, 32'd0);
    chk("t6w_busy", {31'd0, busy}, 32'd0);
    chk("t6w_pend", {28'd0, pending}, 32'd0);
    tick();
    reset = 1'b0;
    pulse(4'b0100);
    tick();
    chk("t6_id_send", {30'd0, xfer_id}, 32'd2);
    chk("t6_busy_send", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6s_id", {30'd0, xfer_id}, 32'd0);
    chk("t6s_busy", {31'd0, busy}, 32'd0);
    chk("t6s_tgl", {31'd0, xfer_tgl}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    base = log_n;
    pulse(4'b0001);
    wait_quiet("t6_quiet");
    chk("t6_log_n", 32'(log_n - base), 32'd1);
    chk("t6_id0", 32'(idlog[base]), 32'd0);
    chk("t6_tgl_end", {31'd0, xfer_tgl}, 32'd1);
    chk("t6_err", {31'd0, tmo_err}, 32'd0);

    chk("ack_before_flip", {31'd0, flip_bad}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
